// File: rtl/imem_boot_loader.sv
// Byte-stream boot loader: packs little-endian words into instruction memory and holds the
// core in reset until the whole image is written (or forever, if the header is rejected).
module imem_boot_loader #(
   parameter int MEM_WORDS = 256,
   parameter int ADDR_W    = 32
) (
   input  logic              clk,
   input  logic              rst,
   input  logic [7:0]        in_data,
   input  logic              in_valid,
   output logic              in_ready,
   output logic              imem_we,
   output logic [ADDR_W-1:0] imem_addr,
   output logic [31:0]       imem_wdata,
   output logic              cpu_rst,
   output logic              done,
   output logic              err,
   output logic [15:0]       words_loaded
);

   typedef enum logic [2:0] {
      HDR_LO,
      HDR_HI,
      LOAD,
      FLUSH,
      DONE,
      ERR
   } state_t;

   state_t      state;
   state_t      state_nxt;
   logic [15:0] word_cnt;
   logic [15:0] hdr_n;
   logic [1:0]  byte_idx;
   logic [23:0] asm_buf;
   logic        accept;
   logic        hdr_bad;
   logic        last_word;

   assign accept    = in_valid & in_ready;
   assign hdr_n     = {in_data, word_cnt[7:0]};
   assign hdr_bad   = (hdr_n == 16'd0) || (hdr_n > 16'(MEM_WORDS));
   assign last_word = (words_loaded == word_cnt - 16'd1);

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state <= HDR_LO;
      end else begin
         state <= state_nxt;
      end
   end

   always_comb begin
      state_nxt = state;
      in_ready  = 1'b0;
      done      = 1'b0;
      err       = 1'b0;
      case (state)
         HDR_LO: begin
            in_ready = 1'b1;
            if (in_valid) state_nxt = HDR_HI;
         end
         HDR_HI: begin
            in_ready = 1'b1;
            if (in_valid) state_nxt = hdr_bad ? ERR : LOAD;
         end
         LOAD: begin
            in_ready = 1'b1;
            if (in_valid && byte_idx == 2'd3 && last_word) state_nxt = FLUSH;
         end
         FLUSH:   state_nxt = DONE;
         DONE:    done = 1'b1;
         ERR:     err = 1'b1;
         default: state_nxt = HDR_LO;
      endcase
      // No byte may be taken while reset is asserted, even though the state reads HDR_LO.
      in_ready = in_ready & ~rst;
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         imem_we      <= 1'b0;
         imem_addr    <= '0;
         imem_wdata   <= '0;
         cpu_rst      <= 1'b1;
         words_loaded <= '0;
         byte_idx     <= '0;
         word_cnt     <= '0;
         asm_buf      <= '0;
      end else begin
         imem_we <= 1'b0;
         // Registered so the core leaves reset one cycle after the final write strobe.
         cpu_rst <= (state_nxt != DONE);
         if (accept) begin
            case (state)
               HDR_LO: word_cnt[7:0]  <= in_data;
               HDR_HI: word_cnt[15:8] <= in_data;
               LOAD: begin
                  byte_idx <= byte_idx + 2'd1;
                  case (byte_idx)
                     2'd0: asm_buf[7:0]   <= in_data;
                     2'd1: asm_buf[15:8]  <= in_data;
                     2'd2: asm_buf[23:16] <= in_data;
                     default: begin
                        imem_wdata   <= {in_data, asm_buf};
                        imem_addr    <= ADDR_W'({words_loaded, 2'b00});
                        imem_we      <= 1'b1;
                        words_loaded <= words_loaded + 16'd1;
                     end
                  endcase
               end
               default: ;
            endcase
         end
      end
   end

endmodule
